// File: rtl/sifive_insight_itl_d_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : sifive_insight_itl_d_responder_if                          |
// | Brief     : TileLink-UL A/D channel bundle for the instruction fetch   |
// |             responder. master = requester side, slave = responder.     |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface sifive_insight_itl_d_responder_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SOURCE_W = 2
);
    // A channel
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [1:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [ADDR_W-1:0]   a_address;

    // D channel
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic [DATA_W-1:0]   d_data;
    logic                d_denied;
    logic                d_corrupt;
    logic                d_user;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data,
               d_denied, d_corrupt, d_user
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data,
               d_denied, d_corrupt, d_user
    );
endinterface
`default_nettype wire

// File: rtl/sifive_insight_itl_d_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sifive_insight_itl_d_responder                              |
// | Brief    : TileLink-UL Get responder in front of a synchronous         |
// |            instruction SRAM. One-cycle read, DEPTH-entry response      |
// |            FIFO with empty-FIFO bypass, credit-based a_ready.          |
// | Options  : INSIGHT_ITL_D_USER_PARITY_EN - d_user carries even parity   |
// |            of d_data (stored per FIFO entry); otherwise d_user = 0.    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module sifive_insight_itl_d_responder #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SOURCE_W = 2,
    parameter int MEM_AW   = 12,
    parameter int DEPTH    = 2
) (
    input  wire logic                  clock,
    input  wire logic                  reset_n,
    sifive_insight_itl_d_responder_if.slave tl,
    output logic                       mem_en,
    output logic [MEM_AW-1:0]          mem_addr,
    input  wire logic [DATA_W-1:0]     mem_rdata
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_occ_w = c_cnt_w + 1;
    localparam logic [c_occ_w-1:0] c_depth    = c_occ_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    // In-flight stage: request accepted last cycle, SRAM data arriving now
    logic                r_inflight;
    logic [SOURCE_W-1:0] r_if_source;
    logic [1:0]          r_if_size;
    logic                r_if_denied;

    // Response FIFO storage
    logic [SOURCE_W-1:0] r_fifo_source [DEPTH];
    logic [1:0]          r_fifo_size   [DEPTH];
    logic                r_fifo_denied [DEPTH];
    logic [DATA_W-1:0]   r_fifo_data   [DEPTH];
`ifdef INSIGHT_ITL_D_USER_PARITY_EN
    logic                r_fifo_user   [DEPTH];
`endif

    // ---------------------------------------------------------------
    // Combinational control
    // ---------------------------------------------------------------
    logic [c_occ_w-1:0]  w_occ;
    logic                w_accept;
    logic                w_hi_zero;
    logic                w_legal;
    logic                w_fifo_empty;
    logic                w_d_valid;
    logic                w_pop;
    logic                w_pop_fifo;
    logic                w_push;
    logic [DATA_W-1:0]   w_push_data;
`ifdef INSIGHT_ITL_D_USER_PARITY_EN
    logic                w_push_user;
`endif

    // Address bits above the SRAM window must be zero; skip when there are none
    generate
        if (ADDR_W > MEM_AW + 2) begin : g_hi_addr
            assign w_hi_zero = (tl.a_address[ADDR_W-1:MEM_AW+2] == '0);
        end else begin : g_no_hi_addr
            assign w_hi_zero = 1'b1;
        end
    endgenerate

    // Every accepted request holds one credit until its response is popped
    assign w_occ        = c_occ_w'(r_count) + c_occ_w'(r_inflight);
    assign tl.a_ready   = (w_occ < c_depth);
    assign w_accept     = reset_n && tl.a_valid && tl.a_ready;
    assign w_legal      = (tl.a_opcode == 3'd4) && (tl.a_size == 2'd2) &&
                          (tl.a_address[1:0] == 2'b00) && w_hi_zero;
    assign mem_en       = w_accept && w_legal;
    assign mem_addr     = tl.a_address[MEM_AW+1:2];

    assign w_fifo_empty = (r_count == '0);
    assign w_d_valid    = !w_fifo_empty || r_inflight;
    assign w_pop        = w_d_valid && tl.d_ready;
    assign w_pop_fifo   = w_pop && !w_fifo_empty;
    // A bypassed response that is taken immediately never enters the FIFO
    assign w_push       = r_inflight && !(w_fifo_empty && w_pop);
    assign w_push_data  = r_if_denied ? '0 : mem_rdata;
`ifdef INSIGHT_ITL_D_USER_PARITY_EN
    assign w_push_user  = ^w_push_data;
`endif

    // D channel: FIFO head when non-empty, otherwise the in-flight bypass
    always_comb begin
        tl.d_valid  = w_d_valid;
        tl.d_opcode = 3'd1;
        tl.d_size   = 2'd0;
        tl.d_source = '0;
        tl.d_data   = '0;
        tl.d_denied = 1'b0;
        tl.d_user   = 1'b0;
        if (!w_fifo_empty) begin
            tl.d_size   = r_fifo_size[r_rd_ptr];
            tl.d_source = r_fifo_source[r_rd_ptr];
            tl.d_data   = r_fifo_data[r_rd_ptr];
            tl.d_denied = r_fifo_denied[r_rd_ptr];
`ifdef INSIGHT_ITL_D_USER_PARITY_EN
            tl.d_user   = r_fifo_user[r_rd_ptr];
`endif
        end else if (r_inflight) begin
            tl.d_size   = r_if_size;
            tl.d_source = r_if_source;
            tl.d_data   = w_push_data;
            tl.d_denied = r_if_denied;
`ifdef INSIGHT_ITL_D_USER_PARITY_EN
            tl.d_user   = w_push_user;
`endif
        end
    end

    assign tl.d_corrupt = tl.d_denied;

    // ---------------------------------------------------------------
    // Sequential logic
    // ---------------------------------------------------------------

    // In-flight stage, FIFO pointers and occupancy; reset drops everything
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_inflight  <= 1'b0;
            r_if_source <= '0;
            r_if_size   <= 2'd0;
            r_if_denied <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_if_source <= tl.a_source;
                r_if_size   <= tl.a_size;
                r_if_denied <= !w_legal;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_fifo) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop_fifo})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload write; contents are don't-care until the pointers say valid
    always_ff @(posedge clock) begin
        if (reset_n && w_push) begin
            r_fifo_source[r_wr_ptr] <= r_if_source;
            r_fifo_size[r_wr_ptr]   <= r_if_size;
            r_fifo_denied[r_wr_ptr] <= r_if_denied;
            r_fifo_data[r_wr_ptr]   <= w_push_data;
`ifdef INSIGHT_ITL_D_USER_PARITY_EN
            r_fifo_user[r_wr_ptr]   <= w_push_user;
`endif
        end
    end

    // Credit scheme must make a push into a full FIFO impossible
    a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
        !(w_push && !w_pop_fifo && (r_count == c_cnt_w'(DEPTH))));

endmodule
`default_nettype wire
